// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared encodings and helpers for the cache memory responder
package mem_if_pkg;

  // Request direction encoding on mem_rw
  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when a byte address maps onto a RAM word (32-bit unsigned compares)
  function automatic logic word_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth);
    logic [31:0] offset;
    offset = addr - base;
    return (addr >= base) && ((offset >> 2) < depth);
  endfunction

endpackage

// File: rtl/mem_sp_ram.sv
// rtl/mem_sp_ram.sv - single-port synchronous RAM with registered read
module mem_sp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write when enabled; read port registers the addressed word every cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - latency-inserting memory responder for the data cache port
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] wr_to_mem,
  output logic [31:0] mem_rd_data,
  output logic        mem_op_finish,
  output logic        mem_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  state_t        state;
  logic [3:0]    count;
  logic          lat_rw;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_data;
  logic          lat_ok;

  logic [29:0]   word_idx;
  logic          req_ok;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_rdata;
  logic          unused_addr_bits;

  // Word index relative to the mapped base; low byte-offset bits are don't-care
  assign word_idx         = mem_addr[31:2] - BASE_ADDR[31:2];
  assign req_ok           = word_in_range(mem_addr, BASE_ADDR, 32'(DEPTH));
  assign unused_addr_bits = &{1'b0, mem_addr[1:0], word_idx[29:AW]};

  // In IDLE the RAM is addressed straight from the request so the registered
  // read already holds the target word by the end of a one-cycle WAIT.
  assign ram_addr = (state == ST_IDLE) ? word_idx[AW-1:0] : lat_idx;
  assign ram_we   = (state == ST_WAIT) && (count == 4'd0) &&
                    (lat_rw == MEM_WR) && lat_ok;

  mem_sp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (lat_data),
    .rdata (ram_rdata)
  );

  // Request FSM: accept and latch, count down the latency, then pulse finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      count         <= 4'd0;
      lat_rw        <= MEM_RD;
      lat_idx       <= '0;
      lat_data      <= 32'd0;
      lat_ok        <= 1'b0;
      mem_rd_data   <= 32'd0;
      mem_op_finish <= 1'b0;
      mem_err       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      mem_op_finish <= 1'b0;
      mem_err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_en) begin
            lat_rw   <= mem_rw;
            lat_idx  <= word_idx[AW-1:0];
            lat_data <= wr_to_mem;
            lat_ok   <= req_ok;
            count    <= 4'(LATENCY - 1);
            busy     <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (count == 4'd0) begin
            if (!lat_ok) begin
              mem_rd_data <= 32'd0;
            end else if (lat_rw == MEM_RD) begin
              mem_rd_data <= ram_rdata;
            end
            mem_op_finish <= 1'b1;
            mem_err       <= ~lat_ok;
            state         <= ST_DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] wr_to_mem;
  logic [31:0] mem_rd_data;
  logic        mem_op_finish;
  logic        mem_err;
  logic        busy;

  int checks;
  int failures;

  mem_responder #(
    .DEPTH     (1024),
    .LATENCY   (N),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_en        (mem_en),
    .mem_rw        (mem_rw),
    .mem_addr      (mem_addr),
    .wr_to_mem     (wr_to_mem),
    .mem_rd_data   (mem_rd_data),
    .mem_op_finish (mem_op_finish),
    .mem_err       (mem_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one request from IDLE, drop mem_en after acceptance, wait for finish
  task automatic run_txn(input string name, input logic rw, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int   busy_cnt;
    logic seen;
    mem_en    = 1'b1;
    mem_rw    = rw;
    mem_addr  = addr;
    wr_to_mem = wdata;
    @(posedge clk);
    #1;
    mem_en   = 1'b0;
    busy_cnt = 0;
    seen     = 1'b0;
    rd       = 32'd0;
    err      = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_cnt++;
      if (mem_op_finish) begin
        seen = 1'b1;
        rd   = mem_rd_data;
        err  = mem_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({name, " finish_seen"}, 32'(seen), 32'd1);
    chk({name, " busy_cycles"}, busy_cnt, N + 1);
    @(posedge clk);
    #1;
    chk({name, " finish_one_cycle"}, 32'(mem_op_finish), 32'd0);
    chk({name, " busy_clear"}, 32'(busy), 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;
  int          gap;
  logic        seen;

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = 32'd0;
    wr_to_mem = 32'd0;

    vecs[0]  = '{"wr0",      1'b1, 32'h0000_0000, 32'd100,  32'd0,   1'b0};
    vecs[1]  = '{"wr4",      1'b1, 32'h0000_0004, 32'd200,  32'd0,   1'b0};
    vecs[2]  = '{"wr8",      1'b1, 32'h0000_0008, 32'd300,  32'd0,   1'b0};
    vecs[3]  = '{"wrC",      1'b1, 32'h0000_000C, 32'd400,  32'd0,   1'b0};
    vecs[4]  = '{"rd4",      1'b0, 32'h0000_0004, 32'd0,    32'd200, 1'b0};
    vecs[5]  = '{"rd8",      1'b0, 32'h0000_0008, 32'd0,    32'd300, 1'b0};
    vecs[6]  = '{"rdC",      1'b0, 32'h0000_000C, 32'd0,    32'd400, 1'b0};
    vecs[7]  = '{"rd7_low",  1'b0, 32'h0000_0007, 32'd0,    32'd200, 1'b0};
    vecs[8]  = '{"wr_last",  1'b1, 32'h0000_0FFC, 32'd999,  32'd0,   1'b0};
    vecs[9]  = '{"rd_last",  1'b0, 32'h0000_0FFC, 32'd0,    32'd999, 1'b0};
    vecs[10] = '{"wr_oor",   1'b1, 32'h0000_1000, 32'd1700, 32'd0,   1'b1};
    vecs[11] = '{"rd_oor",   1'b0, 32'h0000_1000, 32'd0,    32'd0,   1'b1};
    vecs[12] = '{"rd0_keep", 1'b0, 32'h0000_0000, 32'd0,    32'd100, 1'b0};
    vecs[13] = '{"wr10",     1'b1, 32'h0000_0010, 32'd555,  32'd0,   1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_data", mem_rd_data, 32'd0);
    chk("reset finish", 32'(mem_op_finish), 32'd0);
    chk("reset err", 32'(mem_err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven transactions
    for (int i = 0; i < 14; i++) begin
      run_txn(vecs[i].name, vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd, err);
      chk({vecs[i].name, " err"}, 32'(err), 32'(vecs[i].exp_err));
      if (vecs[i].rw == 1'b0) chk({vecs[i].name, " rd_data"}, rd, vecs[i].exp_rd);
    end

    // Back-to-back reads of 0x0 and 0x4 with mem_en held high
    mem_en   = 1'b1;
    mem_rw   = 1'b0;
    mem_addr = 32'h0000_0000;
    seen     = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 40; k++) begin
      if (mem_op_finish) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("b2b first finish_seen", 32'(seen), 32'd1);
    chk("b2b first rd_data", mem_rd_data, 32'd100);
    mem_addr = 32'h0000_0004;
    @(posedge clk);
    #1;
    chk("b2b idle gap busy", 32'(busy), 32'd0);
    gap = 1;
    @(posedge clk);
    #1;
    mem_en = 1'b0;
    gap++;
    chk("b2b second accepted", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mem_op_finish) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      gap++;
    end
    chk("b2b second finish_seen", 32'(seen), 32'd1);
    chk("b2b finish spacing", gap, N + 2);
    chk("b2b second rd_data", mem_rd_data, 32'd200);
    @(posedge clk);
    #1;

    // Prime 0x18, then glitch inputs and drop mem_en during a write to 0x14
    run_txn("wr18", 1'b1, 32'h0000_0018, 32'd50, rd, err);
    mem_en    = 1'b1;
    mem_rw    = 1'b1;
    mem_addr  = 32'h0000_0014;
    wr_to_mem = 32'd777;
    @(posedge clk);
    #1;
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = 32'h0000_0018;
    wr_to_mem = 32'd888;
    seen      = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mem_op_finish) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("glitch finish_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    run_txn("rd14", 1'b0, 32'h0000_0014, 32'd0, rd, err);
    chk("glitch latched data", rd, 32'd777);
    run_txn("rd18", 1'b0, 32'h0000_0018, 32'd0, rd, err);
    chk("glitch other word kept", rd, 32'd50);

    // Reset two cycles into a write of 2700 to 0x10
    mem_en    = 1'b1;
    mem_rw    = 1'b1;
    mem_addr  = 32'h0000_0010;
    wr_to_mem = 32'd2700;
    @(posedge clk);
    #1;
    mem_en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst finish", 32'(mem_op_finish), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (mem_op_finish) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("midrst no finish", 32'(seen), 32'd0);
    run_txn("rd10", 1'b0, 32'h0000_0010, 32'd0, rd, err);
    chk("midrst ram kept", rd, 32'd555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
